decoder_pipe: RTL
=================

Name: decoder_pipe

Overview:
- Parametrised successor to the single-cycle instruction decoder.
- Splits an instruction word into opcode, register selects and immediate, with extended immediates.
- Adds a valid/ready handshake on both sides, one output register stage with back-pressure, and a flush input.
- Adds a two-word long-immediate mode: opcode LONG_OP takes its immediate from the following instruction word.
- Sits between the fetch stage and the register file / ALU issue stage.

Parameters:
- INSTR_W, 16, instruction word width.
- OP_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OP_W].
- REG_W, 3, register-select width; number of registers = 2**REG_W.
- IMM_W, 8, short immediate width; imm = instr[IMM_W-1:0].
- DATA_W, 16, width of the extended immediate output; must be >= IMM_W and <= INSTR_W.
- LONG_OP, 4'hF, opcode value that marks a two-word long-immediate instruction.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  instr is valid.
- in_ready  output  1  block accepts instr this cycle.
- instr  input  INSTR_W  instruction word.
- out_valid  output  1  decoded fields valid.
- out_ready  input  1  downstream accepts the decoded fields.
- op  output  OP_W  opcode.
- rD_select  output  REG_W  destination register, instr[INSTR_W-OP_W-1 -: REG_W].
- rA_select  output  REG_W  source A, instr[IMM_W-1 -: REG_W].
- rB_select  output  REG_W  source B, instr[IMM_W-REG_W-1 -: REG_W].
- immediate  output  DATA_W  extended immediate.
- imm_long  output  1  immediate came from a second word.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. It clears state to S_OP.
- Reset values: out_valid=0, op=0, rD/rA/rB_select=0, immediate=0, imm_long=0.
- Handshake:
  - in_ready = !out_valid || out_ready, in both states; it is 0 during reset.
  - An input is accepted on in_valid && in_ready.
  - An output transfer completes on out_valid && out_ready.
- Output stability: while out_valid && !out_ready, all outputs hold stable.
- FSM states: S_OP (expect opcode word) and S_EXT (expect long-immediate word).
- S_OP, accepted word with op != LONG_OP:
  - Register all fields; imm_long=0; out_valid=1 next cycle (latency 1).
  - Stay in S_OP.
  - Back-to-back accepts with out_ready=1 give one output per cycle.
- S_OP, accepted word with op == LONG_OP:
  - Capture op, rD_select, rA_select and rB_select into holding registers.
  - Go to S_EXT. out_valid falls to 0 if the current output transfers this cycle; otherwise the current output holds.
- S_EXT, accepted word:
  - Outputs = held fields, immediate = instr[DATA_W-1:0], imm_long=1.
  - out_valid=1 next cycle; return to S_OP.
  - The word is never decoded as an opcode.
- Short immediate: immediate = instr[IMM_W-1:0] extended to DATA_W (zero-extended by default; see Optional Feature).
- flush:
  - Next cycle out_valid=0 and state=S_OP, discarding any half-received long instruction.
  - in_ready=0 during the flush cycle, so no input is accepted then.
  - Field outputs keep their old values; they are don't-care while out_valid=0.
- Priority: reset > flush > normal operation.
- Reset or flush in S_EXT: the pending long instruction is dropped, and the next accepted word is treated as an opcode.
- Field overlap: rA/rB overlap the immediate, as in the existing format; all of them are always driven.

Optional Feature:
- Macro: DECODER_SIGNEXT_EN.
- Defined: the short immediate is sign-extended from bit IMM_W-1 to DATA_W.
- Undefined: the short immediate is zero-extended.
- The long immediate is unaffected in both cases.

Decomposition:
- Package decoder_pkg holds:
  - default widths;
  - LONG_OP;
  - state enum {S_OP, S_EXT};
  - field-extraction functions (op, rD, rA, rB, imm).
- One natural sub-module: decoder_fields, purely combinational slicing of one word into fields.
- The top module keeps the FSM, the holding registers and the output register.

Test Plan:
- Reset then instr=16'h3A94, in_valid=1, out_ready=1:
  - next cycle out_valid=1, op=3, rD=5, rA=4, rB=5;
  - immediate=16'h0094 (16'hFF94 with DECODER_SIGNEXT_EN), imm_long=0.
- Long immediate: 16'hF200 then 16'h1234 on consecutive cycles:
  - no output after the first word;
  - one cycle after the second word: op=F, rD=1, immediate=16'h1234, imm_long=1.
- Back-pressure: hold out_ready=0 for 3 cycles after 16'h3A94 with 16'h2400 pending:
  - outputs stable and in_ready=0 throughout;
  - after out_ready=1, 16'h2400 is decoded (op=2, rD=2) the following cycle.
- Flush in S_EXT: accept 16'hF200, assert flush, then send 16'h1234:
  - the word is decoded as op=1, rD=1, immediate=16'h0034, imm_long=0.
- Reset asserted while out_valid=1 and out_ready=0:
  - next cycle all outputs 0, out_valid=0, in_ready=1 after reset deasserts.
- Streaming: 8 short instructions with in_valid=1 and out_ready=1 continuously:
  - 8 outputs on 8 consecutive cycles, in order, no drops or duplicates.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - default widths, long-immediate opcode, FSM states and field slicing helpers
package decoder_pkg;

  localparam int         DEF_INSTR_W = 16;
  localparam int         DEF_OP_W    = 4;
  localparam int         DEF_REG_W   = 3;
  localparam int         DEF_IMM_W   = 8;
  localparam int         DEF_DATA_W  = 16;
  localparam logic [3:0] DEF_LONG_OP = 4'hF;

  // Helpers work on a word widened to MAX_W so any INSTR_W up to that fits.
  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic {S_OP, S_EXT} state_t;

  function automatic word_t slice_bits(input word_t w, input int msb, input int width);
    word_t mask;
    mask = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    return (w >> (msb - width + 1)) & mask;
  endfunction

  function automatic word_t field_op(input word_t w, input int instr_w, input int op_w);
    return slice_bits(w, instr_w - 1, op_w);
  endfunction

  function automatic word_t field_rd(input word_t w, input int instr_w, input int op_w,
                                     input int reg_w);
    return slice_bits(w, instr_w - op_w - 1, reg_w);
  endfunction

  function automatic word_t field_ra(input word_t w, input int imm_w, input int reg_w);
    return slice_bits(w, imm_w - 1, reg_w);
  endfunction

  function automatic word_t field_rb(input word_t w, input int imm_w, input int reg_w);
    return slice_bits(w, imm_w - reg_w - 1, reg_w);
  endfunction

  function automatic word_t field_imm(input word_t w, input int imm_w);
    return slice_bits(w, imm_w - 1, imm_w);
  endfunction

endpackage

// File: rtl/decoder_fields.sv
// rtl/decoder_fields.sv - combinational split of one instruction word into decoder fields
// DECODER_SIGNEXT_EN selects sign extension of the short immediate.
module decoder_fields
  import decoder_pkg::*;
#(
  parameter int              INSTR_W = DEF_INSTR_W,
  parameter int              OP_W    = DEF_OP_W,
  parameter int              REG_W   = DEF_REG_W,
  parameter int              IMM_W   = DEF_IMM_W,
  parameter int              DATA_W  = DEF_DATA_W,
  parameter logic [OP_W-1:0] LONG_OP = OP_W'(DEF_LONG_OP)
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   ra,
  output logic [REG_W-1:0]   rb,
  output logic [DATA_W-1:0]  imm_short,
  output logic [DATA_W-1:0]  imm_word,
  output logic               is_long
);

  word_t            w;
  logic [IMM_W-1:0] imm_raw;

  assign w       = word_t'(instr);
  assign op      = OP_W'(field_op(w, INSTR_W, OP_W));
  assign rd      = REG_W'(field_rd(w, INSTR_W, OP_W, REG_W));
  assign ra      = REG_W'(field_ra(w, IMM_W, REG_W));
  assign rb      = REG_W'(field_rb(w, IMM_W, REG_W));
  assign imm_raw = IMM_W'(field_imm(w, IMM_W));
  assign is_long = (op == LONG_OP);

  // A second-word immediate is taken verbatim, never extended.
  assign imm_word = instr[DATA_W-1:0];

`ifdef DECODER_SIGNEXT_EN
  assign imm_short = DATA_W'($signed(imm_raw));
`else
  assign imm_short = DATA_W'(imm_raw);
`endif

endmodule

// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - pipelined instruction decoder with handshake, flush and two-word long immediates
// DECODER_SIGNEXT_EN selects sign extension of the short immediate.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int              INSTR_W = DEF_INSTR_W,
  parameter int              OP_W    = DEF_OP_W,
  parameter int              REG_W   = DEF_REG_W,
  parameter int              IMM_W   = DEF_IMM_W,
  parameter int              DATA_W  = DEF_DATA_W,
  parameter logic [OP_W-1:0] LONG_OP = OP_W'(DEF_LONG_OP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   rD_select,
  output logic [REG_W-1:0]   rA_select,
  output logic [REG_W-1:0]   rB_select,
  output logic [DATA_W-1:0]  immediate,
  output logic               imm_long
);

  state_t state, state_next;

  logic [OP_W-1:0]   f_op;
  logic [REG_W-1:0]  f_rd, f_ra, f_rb;
  logic [DATA_W-1:0] f_imm_short, f_imm_word;
  logic              f_is_long;

  logic [OP_W-1:0]   hold_op;
  logic [REG_W-1:0]  hold_rd, hold_ra, hold_rb;

  logic accept, load_out, long_start;

  decoder_fields #(
    .INSTR_W (INSTR_W),
    .OP_W    (OP_W),
    .REG_W   (REG_W),
    .IMM_W   (IMM_W),
    .DATA_W  (DATA_W),
    .LONG_OP (LONG_OP)
  ) u_fields (
    .instr     (instr),
    .op        (f_op),
    .rd        (f_rd),
    .ra        (f_ra),
    .rb        (f_rb),
    .imm_short (f_imm_short),
    .imm_word  (f_imm_word),
    .is_long   (f_is_long)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_OP;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_OP;
    end else if (accept) begin
      case (state)
        S_OP:    if (f_is_long) state_next = S_EXT;
        S_EXT:   state_next = S_OP;
        default: state_next = S_OP;
      endcase
    end
  end

  // Reset and flush both close the input so nothing is half-accepted around them.
  always_comb begin
    in_ready   = !reset && !flush && (!out_valid || out_ready);
    accept     = in_valid && in_ready;
    long_start = accept && (state == S_OP) && f_is_long;
    load_out   = accept && ((state == S_EXT) || !f_is_long);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_op <= '0;
      hold_rd <= '0;
      hold_ra <= '0;
      hold_rb <= '0;
    end else if (long_start) begin
      hold_op <= f_op;
      hold_rd <= f_rd;
      hold_ra <= f_ra;
      hold_rb <= f_rb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      op        <= '0;
      rD_select <= '0;
      rA_select <= '0;
      rB_select <= '0;
      immediate <= '0;
      imm_long  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      if (state == S_EXT) begin
        op        <= hold_op;
        rD_select <= hold_rd;
        rA_select <= hold_ra;
        rB_select <= hold_rb;
        immediate <= f_imm_word;
        imm_long  <= 1'b1;
      end else begin
        op        <= f_op;
        rD_select <= f_rd;
        rA_select <= f_ra;
        rB_select <= f_rb;
        immediate <= f_imm_short;
        imm_long  <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
